demux_1_to_2_buffered: RTL and testbench
========================================

Name: demux_1_to_2_buffered

Overview:
- Inverse of the datapath 2-to-1 select: steers one producer stream onto one of two consumer streams.
- `in_select` chooses the destination per word.
- Each destination has its own small FIFO, so a stalled consumer does not block words bound for the other one, except when the stalled side's FIFO is full.
- Used between the writeback/forwarding source and two sinks, e.g. register-file write port and status/debug capture.

Parameters:
- WORD_WIDTH, 32, data width of every word.
- DEPTH, 2, entries per output FIFO. Must be a power of two and >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low (asserted when 0, sampled on the clk rising edge)
- in_valid  input  1  producer offers a word
- in_ready  output  1  block accepts the word this cycle
- in_select  input  1  destination of the offered word: 0 = out0, 1 = out1
- in_data  input  WORD_WIDTH  offered word
- out0_valid  output  1  out0 FIFO non-empty
- out0_ready  input  1  out0 consumer takes the head word
- out0_data  output  WORD_WIDTH  out0 FIFO head
- out0_count  output  $clog2(DEPTH)+1  out0 occupancy
- out1_valid, out1_ready, out1_data, out1_count  same as the out0 signals, for out1

Behaviour:
- Reset (rst==0 at a clock edge):
  - Both FIFOs are emptied; read/write pointers and counts go to 0.
  - out0_valid = out1_valid = 0; out0_data = out1_data = 0.
  - Reset overrides any push or pop in that cycle.
  - Reset mid-stream discards all buffered words; nothing is delivered after reset deasserts until a new push.
- in_ready (combinational):
  - in_ready = (in_select ? !full1 : !full0), where fullN = (countN == DEPTH).
  - in_ready depends only on in_select and registered state, never on out*_ready. There is no pass-through path.
  - While rst==0, in_ready = 0.
- Push:
  - Occurs when in_valid && in_ready at the clock edge.
  - in_data is written to the selected FIFO at its write pointer.
  - That write pointer advances modulo DEPTH.
  - Exactly one FIFO is pushed per cycle, at most.
- Pop:
  - Occurs on outN when outN_valid && outN_ready at the clock edge.
  - outN's read pointer advances modulo DEPTH.
  - out0 and out1 pop independently and may both pop in the same cycle.
- Outputs:
  - outN_valid = (countN != 0).
  - outN_data = entry at outN's read pointer. It is 0 when empty and is held stable while outN_valid && !outN_ready.
- Count update:
  - countN += push_to_N - pop_from_N.
  - Simultaneous push and pop on the same channel leaves the count unchanged.
  - A full channel can pop but cannot push in the same cycle, because in_ready was already 0.
- Latency: a word accepted at edge k is visible on outN_data with outN_valid=1 after edge k, if that FIFO was empty. Minimum one cycle, no combinational in→out path.
- Ordering:
  - Per-channel order is strictly FIFO.
  - No ordering guarantee between out0 and out1.
- Pointer wrap: read and write pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
- Full/empty: full/empty are decided from the count registers, never from pointer equality alone.
- Contract on the producer:
  - in_select and in_data are ignored when in_valid==0.
  - in_valid may drop without a handshake. No protocol assertion is required.
- Write-pointer rule: both pointers of a channel advance only on their own push/pop. The unselected channel's write pointer never moves.

Test Plan:
- Reset then idle: all counts 0, both valids 0, both data 0. in_ready=1 for either select value while rst==1.
- Push 0xA5A5A5A5 with select=0, out0_ready=1:
  - Next cycle out0_valid=1, out0_data=0xA5A5A5A5.
  - The cycle after, out0_valid=0 and out0_count=0.
  - out1 stays invalid throughout.
- Fill out1 with 0x11, 0x22 while out1_ready=0:
  - out1_count=2, and in_ready=0 for select=1.
  - in_ready=1 for select=0; push 0x33 to out0 and out0_data=0x33.
  - Release out1_ready: out1 yields 0x11, then 0x22, in order.
- Simultaneous push and pop on out0 with count=1: count stays 1, data order preserved. Run 8 words to exercise pointer wrap at DEPTH=2.
- Both outputs pop in the same cycle while a third word is pushed to out0: counts update independently and no word is lost or duplicated.
- Assert rst=0 with both FIFOs holding 2 words: after the reset edge counts=0 and valids=0. After deassert, a new push 0x5 appears alone on its output.

Source files
------------

// File: rtl/demux_1_to_2_buffered.sv
// rtl/demux_1_to_2_buffered.sv - one producer stream steered per word into two independently drained FIFOs
module demux_1_to_2_buffered #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_select,
    input  logic [WORD_WIDTH-1:0]    in_data,
    output logic                     out0_valid,
    input  logic                     out0_ready,
    output logic [WORD_WIDTH-1:0]    out0_data,
    output logic [$clog2(DEPTH):0]   out0_count,
    output logic                     out1_valid,
    input  logic                     out1_ready,
    output logic [WORD_WIDTH-1:0]    out1_data,
    output logic [$clog2(DEPTH):0]   out1_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WORD_WIDTH-1:0] mem_q [2][DEPTH];
    logic [WORD_WIDTH-1:0] mem_d [2][DEPTH];
    logic [PW-1:0]         wr_ptr_q [2];
    logic [PW-1:0]         wr_ptr_d [2];
    logic [PW-1:0]         rd_ptr_q [2];
    logic [PW-1:0]         rd_ptr_d [2];
    logic [CW-1:0]         count_q  [2];
    logic [CW-1:0]         count_d  [2];
    logic                  out_ready [2];
    logic                  push [2];
    logic                  pop  [2];

    assign out_ready[0] = out0_ready;
    assign out_ready[1] = out1_ready;

    // Acceptance looks only at the selected channel's own occupancy, never at consumer ready.
    assign in_ready = rst && (in_select ? (count_q[1] != FULL) : (count_q[0] != FULL));

    always_comb begin
        mem_d = mem_q;
        for (int c = 0; c < 2; c++) begin
            push[c]     = in_valid && in_ready && (in_select == (c == 1));
            pop[c]      = (count_q[c] != '0) && out_ready[c];
            wr_ptr_d[c] = push[c] ? wr_ptr_q[c] + PW'(1) : wr_ptr_q[c];
            rd_ptr_d[c] = pop[c]  ? rd_ptr_q[c] + PW'(1) : rd_ptr_q[c];
            count_d[c]  = count_q[c] + CW'(push[c]) - CW'(pop[c]);
            if (push[c]) begin
                mem_d[c][wr_ptr_q[c]] = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int c = 0; c < 2; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                count_q[c]  <= '0;
                for (int e = 0; e < DEPTH; e++) begin
                    mem_q[c][e] <= '0;
                end
            end
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head entry is masked to zero when empty so stale words never leak out.
    assign out0_valid = (count_q[0] != '0);
    assign out1_valid = (count_q[1] != '0);
    assign out0_data  = out0_valid ? mem_q[0][rd_ptr_q[0]] : '0;
    assign out1_data  = out1_valid ? mem_q[1][rd_ptr_q[1]] : '0;
    assign out0_count = count_q[0];
    assign out1_count = count_q[1];
endmodule

// File: tb/tb_demux_1_to_2_buffered.sv
// tb/tb_demux_1_to_2_buffered.sv - table, directed and randomized checks of demux_1_to_2_buffered
module tb_demux_1_to_2_buffered;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_select = 1'b0;
    logic [31:0] in_data = '0;
    logic        out0_valid, out1_valid;
    logic        out0_ready = 1'b0, out1_ready = 1'b0;
    logic [31:0] out0_data, out1_data;
    logic [1:0]  out0_count, out1_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    demux_1_to_2_buffered #(.WORD_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_select(in_select), .in_data(in_data),
        .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data), .out0_count(out0_count),
        .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data), .out1_count(out1_count)
    );

    typedef struct {
        logic        rst, iv, sel;
        logic [31:0] d;
        logic        r0, r1;
        logic        ir;
        logic        v0;
        logic [31:0] d0;
        logic [1:0]  c0;
        logic        v1;
        logic [31:0] d1;
        logic [1:0]  c1;
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t mk(logic r, logic iv, logic sel, logic [31:0] d, logic r0, logic r1, logic ir,
                                logic v0, logic [31:0] d0, logic [1:0] c0,
                                logic v1, logic [31:0] d1, logic [1:0] c1);
        vec_t v;
        v.rst = r; v.iv = iv; v.sel = sel; v.d = d; v.r0 = r0; v.r1 = r1; v.ir = ir;
        v.v0 = v0; v.d0 = d0; v.c0 = c0; v.v1 = v1; v.d1 = d1; v.c1 = c1;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic r, logic iv, logic sel, logic [31:0] d, logic r0, logic r1);
        rst = r; in_valid = iv; in_select = sel; in_data = d; out0_ready = r0; out1_ready = r1;
    endtask

    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic [31:0] w [0:8];

    initial begin
        //            rst iv sel data          r0 r1 | ir v0 d0            c0 v1 d1            c1
        tbl[0]  = mk(0, 1, 0, 32'hDEAD_BEEF, 0, 0,   0, 0, 32'h0,        0, 0, 32'h0,        0);
        tbl[1]  = mk(1, 0, 1, 32'h0,         0, 0,   1, 0, 32'h0,        0, 0, 32'h0,        0);
        tbl[2]  = mk(1, 0, 0, 32'h0,         0, 0,   1, 0, 32'h0,        0, 0, 32'h0,        0);
        tbl[3]  = mk(1, 1, 0, 32'hA5A5_A5A5, 1, 0,   1, 1, 32'hA5A5_A5A5, 1, 0, 32'h0,       0);
        tbl[4]  = mk(1, 0, 0, 32'h0,         1, 0,   1, 0, 32'h0,        0, 0, 32'h0,        0);
        tbl[5]  = mk(1, 1, 1, 32'h11,        0, 0,   1, 0, 32'h0,        0, 1, 32'h11,       1);
        tbl[6]  = mk(1, 1, 1, 32'h22,        0, 0,   1, 0, 32'h0,        0, 1, 32'h11,       2);
        tbl[7]  = mk(1, 1, 1, 32'h99,        0, 0,   0, 0, 32'h0,        0, 1, 32'h11,       2);
        tbl[8]  = mk(1, 1, 0, 32'h33,        0, 0,   1, 1, 32'h33,       1, 1, 32'h11,       2);
        tbl[9]  = mk(1, 0, 1, 32'h0,         0, 1,   0, 1, 32'h33,       1, 1, 32'h22,       1);
        tbl[10] = mk(1, 0, 0, 32'h0,         1, 1,   1, 0, 32'h0,        0, 0, 32'h0,        0);
        tbl[11] = mk(1, 1, 0, 32'h44,        0, 0,   1, 1, 32'h44,       1, 0, 32'h0,        0);
        tbl[12] = mk(1, 1, 1, 32'h55,        0, 0,   1, 1, 32'h44,       1, 1, 32'h55,       1);
        tbl[13] = mk(1, 1, 0, 32'h66,        1, 1,   1, 1, 32'h66,       1, 0, 32'h0,        0);
        tbl[14] = mk(1, 0, 0, 32'h0,         1, 0,   1, 0, 32'h0,        0, 0, 32'h0,        0);
        tbl[15] = mk(1, 1, 0, 32'h1,         0, 0,   1, 1, 32'h1,        1, 0, 32'h0,        0);
        tbl[16] = mk(1, 1, 0, 32'h2,         0, 0,   1, 1, 32'h1,        2, 0, 32'h0,        0);
        tbl[17] = mk(1, 1, 1, 32'h3,         0, 0,   1, 1, 32'h1,        2, 1, 32'h3,        1);
        tbl[18] = mk(1, 1, 1, 32'h4,         0, 0,   1, 1, 32'h1,        2, 1, 32'h3,        2);
        tbl[19] = mk(0, 1, 0, 32'h7,         1, 1,   0, 0, 32'h0,        0, 0, 32'h0,        0);
        tbl[20] = mk(1, 1, 1, 32'h5,         0, 0,   1, 0, 32'h0,        0, 1, 32'h5,        1);
        tbl[21] = mk(1, 0, 1, 32'h0,         0, 1,   1, 0, 32'h0,        0, 0, 32'h0,        0);

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].iv, tbl[i].sel, tbl[i].d, tbl[i].r0, tbl[i].r1);
            #1 chk($sformatf("row%0d in_ready", i), 64'(in_ready), 64'(tbl[i].ir));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d v0", i), 64'(out0_valid), 64'(tbl[i].v0));
            chk($sformatf("row%0d d0", i), 64'(out0_data),  64'(tbl[i].d0));
            chk($sformatf("row%0d c0", i), 64'(out0_count), 64'(tbl[i].c0));
            chk($sformatf("row%0d v1", i), 64'(out1_valid), 64'(tbl[i].v1));
            chk($sformatf("row%0d d1", i), 64'(out1_data),  64'(tbl[i].d1));
            chk($sformatf("row%0d c1", i), 64'(out1_count), 64'(tbl[i].c1));
        end

        // Steady push+pop on out0 at occupancy 1: eight words walk the pointers around several times.
        for (int i = 0; i < 9; i++) w[i] = 32'h1000 + 32'(i) * 32'h0101;
        @(negedge clk);
        drive(1, 1, 0, w[0], 0, 0);
        @(posedge clk);
        for (int i = 1; i < 9; i++) begin
            @(negedge clk);
            drive(1, 1, 0, w[i], 1, 0);
            #1;
            chk($sformatf("wrap%0d head", i), 64'(out0_data), 64'(w[i-1]));
            chk($sformatf("wrap%0d in_ready", i), 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
            chk($sformatf("wrap%0d c0", i), 64'(out0_count), 64'd1);
            chk($sformatf("wrap%0d d0", i), 64'(out0_data), 64'(w[i]));
        end
        @(negedge clk);
        drive(1, 0, 0, 0, 1, 0);
        @(posedge clk);
        #1 chk("wrap drained", 64'({out0_valid, out0_count}), 64'd0);

        // Randomized traffic against a queue-based reference.
        q0.delete();
        q1.delete();
        for (int n = 0; n < 3000; n++) begin
            logic r, iv, sel, r0, r1, exp_ir;
            logic [31:0] d;
            @(negedge clk);
            r   = ($urandom_range(0, 59) != 0);
            iv  = ($urandom_range(0, 3) != 0);
            sel = 1'($urandom);
            d   = $urandom;
            r0  = ($urandom_range(0, 2) != 0);
            r1  = ($urandom_range(0, 4) < 2);
            drive(r, iv, sel, d, r0, r1);
            #1;
            exp_ir = r && ((sel ? q1.size() : q0.size()) < DEPTH);
            chk("rnd in_ready", 64'(in_ready), 64'(exp_ir));
            chk("rnd c0", 64'(out0_count), 64'(q0.size()));
            chk("rnd c1", 64'(out1_count), 64'(q1.size()));
            chk("rnd d0", 64'(out0_data), 64'(q0.size() != 0 ? q0[0] : 32'h0));
            chk("rnd d1", 64'(out1_data), 64'(q1.size() != 0 ? q1[0] : 32'h0));
            @(posedge clk);
            if (!r) begin
                q0.delete();
                q1.delete();
            end else begin
                if (r0 && q0.size() != 0) void'(q0.pop_front());
                if (r1 && q1.size() != 0) void'(q1.pop_front());
                if (iv && exp_ir) begin
                    if (sel) q1.push_back(d);
                    else     q0.push_back(d);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
